uart_rx_param: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver. Adds configurable data width, parity mode and stop-bit count, 3-sample majority voting at mid-bit, and per-word parity/framing error flags. Adds overrun detection on a valid/ready output handshake. Sits between the pad-side rx line and any byte-stream consumer, e.g. a FIFO or command decoder.

---
 rtl/uart_rx_param.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver.
//
// Receives asynchronous serial frames of the form
//   start(0) | DATA_BITS data bits, LSB first | optional parity | STOP_BITS stop bits
// and presents each word on a valid/ready output handshake. Each bit is
// decided by a 3-sample majority vote around mid-bit. Parity and framing
// errors travel with the word they belong to. A word that completes while
// the previous one is still unaccepted is dropped and reported on
// overrun_error.
//
// Parameters:
//   CLK_RATE   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         synchronous active-low reset
//   rx              asynchronous serial input, idle high
//   data            received word, stable while data_val=1
//   data_val        word available
//   ready           consumer accepts the word when data_val & ready
//   parity_error    parity mismatch for the presented word
//   frame_error     a stop bit was sampled low for the presented word
//   overrun_error   one-cycle pulse when a completed word is dropped
//   baud_rate_error constant 1 when there are fewer than 4 clocks per bit

module uart_rx_param #(
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_val,
    input  logic                 ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 baud_rate_error
);

    localparam int CLKS_PER_BAUD      = CLK_RATE / BAUD_RATE;
    localparam int HALF_CLKS_PER_BAUD = CLKS_PER_BAUD / 2;
    localparam int CNT_W = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    // Counter values of interest within one bit period.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF_CLKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF_CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF_CLKS_PER_BAUD + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    localparam logic PAR_EN    = (PARITY != 0);
    localparam logic PAR_ODD   = (PARITY == 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DELIVER,
        ST_BREAK
    } state_t;

    // Input synchroniser plus one extra stage for falling-edge detection.
    logic rx_meta_reg;
    logic rxs_reg;
    logic rxs_prev_reg;

    state_t               state_reg,    state_next;
    logic [CNT_W-1:0]     cnt_reg,      cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic [1:0]           samp_reg,     samp_next;
    logic                 perr_reg,     perr_next;
    logic                 ferr_reg,     ferr_next;

    logic [DATA_BITS-1:0] data_reg;
    logic                 data_val_reg;
    logic                 parity_error_reg;
    logic                 frame_error_reg;
    logic                 overrun_reg;

    logic vote;
    logic at_vote;
    logic at_last;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg  <= rx;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    // Majority of the samples taken at mid-1 and mid with the live value
    // at mid+1, so a single-clock disturbance near mid-bit is rejected.
    assign vote    = (samp_reg[0] & samp_reg[1]) |
                     (samp_reg[0] & rxs_reg)     |
                     (samp_reg[1] & rxs_reg);
    assign at_vote = (cnt_reg == CNT_VOTE);
    assign at_last = (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            samp_reg     <= 2'b11;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            shift_reg    <= shift_next;
            samp_reg     <= samp_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + CNT_W'(1);
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        shift_next    = shift_reg;
        samp_next     = samp_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;

        if (cnt_reg == CNT_S0) begin
            samp_next[0] = rxs_reg;
        end
        if (cnt_reg == CNT_S1) begin
            samp_next[1] = rxs_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (rxs_prev_reg && !rxs_reg) begin
                    state_next = ST_START;
                    perr_next  = 1'b0;
                    ferr_next  = 1'b0;
                end
            end

            ST_START: begin
                if (at_vote && vote) begin
                    // Start bit did not hold low through mid-bit: a glitch.
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (at_last) begin
                    state_next   = ST_DATA;
                    cnt_next     = '0;
                    bit_cnt_next = '0;
                end
            end

            ST_DATA: begin
                if (at_vote) begin
                    // LSB arrives first, so shift in at the top.
                    shift_next = {vote, shift_reg[DATA_BITS-1:1]};
                end
                if (at_last) begin
                    cnt_next = '0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next    = PAR_EN ? ST_PARITY : ST_STOP;
                        stop_cnt_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (at_vote) begin
                    // XOR over data and parity is 1 for odd, 0 for even.
                    perr_next = (((^shift_reg) ^ vote) != PAR_ODD);
                end
                if (at_last) begin
                    state_next    = ST_STOP;
                    cnt_next      = '0;
                    stop_cnt_next = 1'b0;
                end
            end

            ST_STOP: begin
                if (at_vote) begin
                    ferr_next = ferr_reg | ~vote;
                end
                // The last stop bit is not waited out: delivering at its
                // vote leaves half a bit to rearm for the next start edge.
                if (at_vote && (stop_cnt_reg == STOP_LAST)) begin
                    state_next = ST_DELIVER;
                    cnt_next   = '0;
                end else if (at_last) begin
                    cnt_next      = '0;
                    stop_cnt_next = 1'b1;
                end
            end

            ST_DELIVER: begin
                cnt_next   = '0;
                state_next = ferr_reg ? ST_BREAK : ST_IDLE;
            end

            ST_BREAK: begin
                // A line held low after a framing error must go high
                // before another start bit is accepted.
                cnt_next = '0;
                if (rxs_reg) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg         <= '0;
            data_val_reg     <= 1'b0;
            parity_error_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (state_reg == ST_DELIVER) begin
                if (!data_val_reg || ready) begin
                    // Free slot, or the held word leaves this same edge:
                    // the reload wins and data_val stays high.
                    data_reg         <= shift_reg;
                    parity_error_reg <= perr_reg;
                    frame_error_reg  <= ferr_reg;
                    data_val_reg     <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (data_val_reg && ready) begin
                data_val_reg     <= 1'b0;
                parity_error_reg <= 1'b0;
                frame_error_reg  <= 1'b0;
            end
        end
    end

    assign data            = data_reg;
    assign data_val        = data_val_reg;
    assign parity_error    = parity_error_reg;
    assign frame_error     = frame_error_reg;
    assign overrun_error   = overrun_reg;
    assign baud_rate_error = (CLKS_PER_BAUD < 4);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- self-checking bench for uart_rx_param.
// Several receiver builds (8N1, 8E1, 8O1, 8N2, 5N1, 9N1 at 16 clk/bit and
// one with too few clocks per bit) are driven from frame-building tasks.
// Each accepted word is captured into a per-build queue and compared
// against a model computed from the frame contents.

`timescale 1ns/1ps

module tb_uart_rx_param;

    localparam int CR = 16000;
    localparam int BR = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic rx_a, rx_p, rx_s, rx_5, rx_9, rx_b;
    logic ready_a, ready_1;

    logic [7:0] data_a, data_e, data_o, data_s, data_b;
    logic [4:0] data_5;
    logic [8:0] data_9;
    logic dv_a, dv_e, dv_o, dv_s, dv_5, dv_9, dv_b;
    logic pe_a, pe_e, pe_o, pe_s, pe_5, pe_9, pe_b;
    logic fe_a, fe_e, fe_o, fe_s, fe_5, fe_9, fe_b;
    logic ov_a, ov_e, ov_o, ov_s, ov_5, ov_9, ov_b;
    logic be_a, be_e, be_o, be_s, be_5, be_9, be_b;

    int errors = 0;
    int checks = 0;

    uart_rx_param #(.CLK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset_n(reset_n), .rx(rx_a), .data(data_a), .data_val(dv_a), .ready(ready_a),
        .parity_error(pe_a), .frame_error(fe_a), .overrun_error(ov_a), .baud_rate_error(be_a));
    uart_rx_param #(.CLK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
        .clk(clk), .reset_n(reset_n), .rx(rx_p), .data(data_e), .data_val(dv_e), .ready(ready_1),
        .parity_error(pe_e), .frame_error(fe_e), .overrun_error(ov_e), .baud_rate_error(be_e));
    uart_rx_param #(.CLK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o (
        .clk(clk), .reset_n(reset_n), .rx(rx_p), .data(data_o), .data_val(dv_o), .ready(ready_1),
        .parity_error(pe_o), .frame_error(fe_o), .overrun_error(ov_o), .baud_rate_error(be_o));
    uart_rx_param #(.CLK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_s (
        .clk(clk), .reset_n(reset_n), .rx(rx_s), .data(data_s), .data_val(dv_s), .ready(ready_1),
        .parity_error(pe_s), .frame_error(fe_s), .overrun_error(ov_s), .baud_rate_error(be_s));
    uart_rx_param #(.CLK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5 (
        .clk(clk), .reset_n(reset_n), .rx(rx_5), .data(data_5), .data_val(dv_5), .ready(ready_1),
        .parity_error(pe_5), .frame_error(fe_5), .overrun_error(ov_5), .baud_rate_error(be_5));
    uart_rx_param #(.CLK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9 (
        .clk(clk), .reset_n(reset_n), .rx(rx_9), .data(data_9), .data_val(dv_9), .ready(ready_1),
        .parity_error(pe_9), .frame_error(fe_9), .overrun_error(ov_9), .baud_rate_error(be_9));
    uart_rx_param #(.CLK_RATE(3000), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_b (
        .clk(clk), .reset_n(reset_n), .rx(rx_b), .data(data_b), .data_val(dv_b), .ready(ready_1),
        .parity_error(pe_b), .frame_error(fe_b), .overrun_error(ov_b), .baud_rate_error(be_b));

    // Captured words: {parity_error, frame_error, data zero-extended to 9 bits}
    logic [10:0] q_a[$], q_e[$], q_o[$], q_s[$], q_5[$], q_9[$];
    int ov_cnt_a = 0;
    int ov_cnt_other = 0;

    // Capture on the falling edge: a word seen with data_val & ready here is
    // taken by the DUT at the following rising edge.
    always @(negedge clk) begin
        if (dv_a && ready_a) q_a.push_back({pe_a, fe_a, 1'b0, data_a});
        if (dv_e && ready_1) q_e.push_back({pe_e, fe_e, 1'b0, data_e});
        if (dv_o && ready_1) q_o.push_back({pe_o, fe_o, 1'b0, data_o});
        if (dv_s && ready_1) q_s.push_back({pe_s, fe_s, 1'b0, data_s});
        if (dv_5 && ready_1) q_5.push_back({pe_5, fe_5, 4'b0, data_5});
        if (dv_9 && ready_1) q_9.push_back({pe_9, fe_9, data_9});
        if (ov_a) ov_cnt_a++;
        if (ov_e || ov_o || ov_s || ov_5 || ov_9) ov_cnt_other++;
    end

    // Reference: what the receiver must present for a given frame.
    // pmode 0 none, 1 odd, 2 even; pbit is the parity bit placed on the line.
    function automatic logic [10:0] model(input logic [8:0] val, input int nbits, input int pmode,
                                          input int pbit, input logic st1, input logic st2,
                                          input int nstop);
        logic [8:0] v;
        int ones;
        logic pe;
        logic fe;
        v    = val & 9'((1 << nbits) - 1);
        ones = $countones(v) + ((pmode != 0) ? pbit : 0);
        if (pmode == 1)      pe = ((ones % 2) != 1);
        else if (pmode == 2) pe = ((ones % 2) != 0);
        else                 pe = 1'b0;
        fe = !st1 || ((nstop == 2) && !st2);
        return {pe, fe, v};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int ln, input logic v);
        case (ln)
            0: rx_a = v;
            1: rx_p = v;
            2: rx_s = v;
            3: rx_5 = v;
            default: rx_9 = v;
        endcase
    endtask

    // Drive one frame, 16 clocks per bit. glitch inverts every data bit for
    // a single clock near mid-bit; rst_idx pulses reset_n inside that bit.
    task automatic send_frame(input int ln, input int nbits, input logic [8:0] val, input int pbit,
                              input logic st1, input logic st2, input int nstop,
                              input bit glitch, input int rst_idx);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(val[i]);
        if (pbit >= 0) bits.push_back(pbit[0]);
        bits.push_back(st1);
        if (nstop == 2) bits.push_back(st2);
        for (int i = 0; i < bits.size(); i++) begin
            set_rx(ln, bits[i]);
            if (glitch && i >= 1 && i <= nbits) begin
                tick(9);
                set_rx(ln, ~bits[i]);
                tick(1);
                set_rx(ln, bits[i]);
                tick(6);
            end else if (i == rst_idx) begin
                tick(4);
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
                tick(11);
            end else begin
                tick(16);
            end
        end
    endtask

    task automatic test_reset();
        tick(3);
        reset_n = 1'b1;
        tick(2);
        checks++;
        if ({dv_a, pe_a, fe_a, ov_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {dv_a, pe_a, fe_a, ov_a});
        end
        checks++;
        if (data_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", data_a);
        end
        checks++;
        if ({be_a, be_e, be_o, be_s, be_5, be_9} !== 6'b0) begin
            errors++;
            $display("FAIL baud_err_ok: got %b expected 000000", {be_a, be_e, be_o, be_s, be_5, be_9});
        end
        checks++;
        if (be_b !== 1'b1) begin
            errors++;
            $display("FAIL baud_err_slow: got %b expected 1", be_b);
        end
        checks++;
        if ($isunknown({data_b, dv_b, pe_b, fe_b, ov_b})) begin
            errors++;
            $display("FAIL slow_no_x: got %b expected no X", {data_b, dv_b, pe_b, fe_b, ov_b});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_q[$];
        logic [10:0] got;
        logic [7:0] vals[$];
        vals = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A, 8'h55};
        for (int i = 0; i < 5; i++) vals.push_back(8'($urandom_range(0, 255)));
        foreach (vals[i]) begin
            send_frame(0, 8, {1'b0, vals[i]}, -1, 1'b1, 1'b1, 1, 1'b0, -1);
            exp_q.push_back(model({1'b0, vals[i]}, 8, 0, 0, 1'b1, 1'b1, 1));
        end
        tick(5);
        checks++;
        if (q_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected %0d", q_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (q_a.size() > 0) begin
                got = q_a.pop_front();
                checks++;
                if (got !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h expected %h", i, got, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] v;
        int p;
        logic [10:0] got;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                v = 8'h68;
                p = (i == 0) ? 1 : 0;
            end else begin
                v = 8'($urandom_range(0, 255));
                p = int'($urandom_range(0, 1));
            end
            send_frame(1, 8, {1'b0, v}, p, 1'b1, 1'b1, 1, 1'b0, -1);
            tick(4);
            checks++;
            if (q_e.size() != 1) begin
                errors++;
                $display("FAIL even_count%0d: got %0d expected 1", i, q_e.size());
            end else begin
                got = q_e.pop_front();
                if (got !== model({1'b0, v}, 8, 2, p, 1'b1, 1'b1, 1)) begin
                    errors++;
                    $display("FAIL even_word%0d: got %h expected %h", i, got,
                             model({1'b0, v}, 8, 2, p, 1'b1, 1'b1, 1));
                end
            end
            checks++;
            if (q_o.size() != 1) begin
                errors++;
                $display("FAIL odd_count%0d: got %0d expected 1", i, q_o.size());
            end else begin
                got = q_o.pop_front();
                if (got !== model({1'b0, v}, 8, 1, p, 1'b1, 1'b1, 1)) begin
                    errors++;
                    $display("FAIL odd_word%0d: got %h expected %h", i, got,
                             model({1'b0, v}, 8, 1, p, 1'b1, 1'b1, 1));
                end
            end
        end
    endtask

    task automatic test_stop_break();
        logic [10:0] got;
        logic [7:0] vals[4];
        logic st1s[4];
        logic st2s[4];
        vals = '{8'hA5, 8'h3C, 8'hC3, 8'($urandom_range(0, 255))};
        st1s = '{1'b1, 1'b1, 1'b0, 1'b1};
        st2s = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_frame(2, 8, {1'b0, vals[i]}, -1, st1s[i], st2s[i], 2, 1'b0, -1);
            tick(4);
            checks++;
            if (q_s.size() != 1) begin
                errors++;
                $display("FAIL stop_count%0d: got %0d expected 1", i, q_s.size());
            end else begin
                got = q_s.pop_front();
                if (got !== model({1'b0, vals[i]}, 8, 0, 0, st1s[i], st2s[i], 2)) begin
                    errors++;
                    $display("FAIL stop_word%0d: got %h expected %h", i, got,
                             model({1'b0, vals[i]}, 8, 0, 0, st1s[i], st2s[i], 2));
                end
            end
            if (i == 0) begin
                // Line stays low (break) for 40 bit times.
                tick(40 * 16);
                checks++;
                if (q_s.size() != 0 || dv_s !== 1'b0) begin
                    errors++;
                    $display("FAIL break_quiet: got %0d words dv=%b expected 0 words dv=0", q_s.size(), dv_s);
                end
                rx_s = 1'b1;
                tick(32);
            end
        end
    endtask

    task automatic test_overrun();
        logic [10:0] got;
        int ov0;
        ready_a = 1'b0;
        send_frame(0, 8, 9'h011, -1, 1'b1, 1'b1, 1, 1'b0, -1);
        tick(4);
        checks++;
        if (dv_a !== 1'b1 || data_a !== 8'h11) begin
            errors++;
            $display("FAIL ovr_hold1: got dv=%b data=%h expected dv=1 data=11", dv_a, data_a);
        end
        ov0 = ov_cnt_a;
        send_frame(0, 8, 9'h022, -1, 1'b1, 1'b1, 1, 1'b0, -1);
        tick(4);
        checks++;
        if (ov_cnt_a - ov0 != 1) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d pulses expected 1", ov_cnt_a - ov0);
        end
        checks++;
        if (dv_a !== 1'b1 || data_a !== 8'h11 || q_a.size() != 0) begin
            errors++;
            $display("FAIL ovr_hold2: got dv=%b data=%h q=%0d expected dv=1 data=11 q=0", dv_a, data_a, q_a.size());
        end
        ready_a = 1'b1;
        tick(1);
        checks++;
        if (dv_a !== 1'b0) begin
            errors++;
            $display("FAIL ovr_accept_dv: got %b expected 0", dv_a);
        end
        checks++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL ovr_accept_cnt: got %0d expected 1", q_a.size());
        end else begin
            got = q_a.pop_front();
            if (got !== model(9'h011, 8, 0, 0, 1'b1, 1'b1, 1)) begin
                errors++;
                $display("FAIL ovr_accept_word: got %h expected %h", got, model(9'h011, 8, 0, 0, 1'b1, 1'b1, 1));
            end
        end
        send_frame(0, 8, 9'h033, -1, 1'b1, 1'b1, 1, 1'b0, -1);
        tick(4);
        checks++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL ovr_next_cnt: got %0d expected 1", q_a.size());
        end else begin
            got = q_a.pop_front();
            if (got !== model(9'h033, 8, 0, 0, 1'b1, 1'b1, 1)) begin
                errors++;
                $display("FAIL ovr_next_word: got %h expected %h", got, model(9'h033, 8, 0, 0, 1'b1, 1'b1, 1));
            end
        end
    endtask

    task automatic test_glitch();
        logic [10:0] got;
        logic [7:0] vals[3];
        rx_a = 1'b0;
        tick(3);
        rx_a = 1'b1;
        tick(40);
        checks++;
        if (q_a.size() != 0 || dv_a !== 1'b0) begin
            errors++;
            $display("FAIL start_glitch: got %0d words dv=%b expected 0 words dv=0", q_a.size(), dv_a);
        end
        vals = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h5A};
        for (int i = 0; i < 3; i++) begin
            send_frame(0, 8, {1'b0, vals[i]}, -1, 1'b1, 1'b1, 1, 1'b1, -1);
            tick(4);
            checks++;
            if (q_a.size() != 1) begin
                errors++;
                $display("FAIL vote_count%0d: got %0d expected 1", i, q_a.size());
            end else begin
                got = q_a.pop_front();
                if (got !== model({1'b0, vals[i]}, 8, 0, 0, 1'b1, 1'b1, 1)) begin
                    errors++;
                    $display("FAIL vote_word%0d: got %h expected %h", i, got,
                             model({1'b0, vals[i]}, 8, 0, 0, 1'b1, 1'b1, 1));
                end
            end
        end
    endtask

    task automatic test_widths();
        logic [10:0] got;
        logic [8:0] v5[2];
        logic [8:0] v9[2];
        v5 = '{9'h015, 9'($urandom_range(0, 31))};
        v9 = '{9'h1A5, 9'($urandom_range(0, 511))};
        for (int i = 0; i < 2; i++) begin
            send_frame(3, 5, v5[i], -1, 1'b1, 1'b1, 1, 1'b0, -1);
            send_frame(4, 9, v9[i], -1, 1'b1, 1'b1, 1, 1'b0, -1);
            tick(4);
            checks++;
            if (q_5.size() != 1) begin
                errors++;
                $display("FAIL w5_count%0d: got %0d expected 1", i, q_5.size());
            end else begin
                got = q_5.pop_front();
                if (got !== model(v5[i], 5, 0, 0, 1'b1, 1'b1, 1)) begin
                    errors++;
                    $display("FAIL w5_word%0d: got %h expected %h", i, got, model(v5[i], 5, 0, 0, 1'b1, 1'b1, 1));
                end
            end
            checks++;
            if (q_9.size() != 1) begin
                errors++;
                $display("FAIL w9_count%0d: got %0d expected 1", i, q_9.size());
            end else begin
                got = q_9.pop_front();
                if (got !== model(v9[i], 9, 0, 0, 1'b1, 1'b1, 1)) begin
                    errors++;
                    $display("FAIL w9_word%0d: got %h expected %h", i, got, model(v9[i], 9, 0, 0, 1'b1, 1'b1, 1));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] got;
        // 0xF5: data bits 4..7 and stop are high, so no edge follows the reset.
        send_frame(0, 8, 9'h0F5, -1, 1'b1, 1'b1, 1, 1'b0, 5);
        tick(20);
        checks++;
        if (q_a.size() != 0 || dv_a !== 1'b0 || data_a !== 8'h00) begin
            errors++;
            $display("FAIL midreset: got q=%0d dv=%b data=%h expected q=0 dv=0 data=00", q_a.size(), dv_a, data_a);
        end
        send_frame(0, 8, 9'h077, -1, 1'b1, 1'b1, 1, 1'b0, -1);
        tick(4);
        checks++;
        if (q_a.size() != 1) begin
            errors++;
            $display("FAIL midreset_next_cnt: got %0d expected 1", q_a.size());
        end else begin
            got = q_a.pop_front();
            if (got !== model(9'h077, 8, 0, 0, 1'b1, 1'b1, 1)) begin
                errors++;
                $display("FAIL midreset_next_word: got %h expected %h", got, model(9'h077, 8, 0, 0, 1'b1, 1'b1, 1));
            end
        end
        checks++;
        if (ov_cnt_other != 0) begin
            errors++;
            $display("FAIL stray_overrun: got %0d expected 0", ov_cnt_other);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rx_a = 1'b1; rx_p = 1'b1; rx_s = 1'b1; rx_5 = 1'b1; rx_9 = 1'b1; rx_b = 1'b1;
        ready_a = 1'b1;
        ready_1 = 1'b1;
        test_reset();
        test_back_to_back();
        test_parity();
        test_stop_break();
        test_overrun();
        test_glitch();
        test_widths();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
